// File: rtl/ff_bank_sched.sv
// Round-robin scheduler that owns a shared WIDTH-bit flop bank. Each granted requester
// runs one LOAD/CLEAR/PRESET/COMPARE, and the block reports whether the result is pat_x or pat_y.
module ff_bank_sched #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [NREQ-1:0]         req,
  input  logic [2*NREQ-1:0]       op,
  input  logic [WIDTH*NREQ-1:0]   wdata,
  input  logic [WIDTH-1:0]        pat_x,
  input  logic [WIDTH-1:0]        pat_y,
  output logic [NREQ-1:0]         gnt,
  output logic                    busy,
  output logic                    done,
  output logic                    match,
  output logic [WIDTH-1:0]        q,
  output logic [WIDTH-1:0]        qb
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, APPLY, CHECK} state_t;
  typedef enum logic [1:0] {OP_LOAD = 2'b00, OP_CLEAR = 2'b01,
                            OP_PRESET = 2'b10, OP_COMPARE = 2'b11} op_t;

  state_t            state, state_n;
  logic [WIDTH-1:0]  q_n;
  logic [NREQ-1:0]   gnt_n;
  logic              busy_n, done_n, match_n;
  logic [PW-1:0]     rr_ptr, rr_ptr_n;
  logic [PW-1:0]     win, win_n;
  op_t               lop, lop_n;
  logic [WIDTH-1:0]  lwd, lwd_n;

  // Round-robin search starting at rr_ptr
  logic              found;
  logic [PW-1:0]     pick;
  logic [PW-1:0]     cand;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = PW'((32'(rr_ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Next-state and next-register logic
  always_comb begin
    state_n  = state;
    q_n      = q;
    gnt_n    = gnt;
    busy_n   = busy;
    done_n   = 1'b0;
    match_n  = match;
    rr_ptr_n = rr_ptr;
    win_n    = win;
    lop_n    = lop;
    lwd_n    = lwd;

    case (state)
      IDLE: begin
        if (found) begin
          win_n   = pick;
          lop_n   = op_t'(op[2*pick +: 2]);
          lwd_n   = wdata[WIDTH*pick +: WIDTH];
          gnt_n   = NREQ'(1) << pick;
          busy_n  = 1'b1;
          state_n = APPLY;
        end else begin
          gnt_n  = '0;
          busy_n = 1'b0;
        end
      end

      APPLY: begin
        case (lop)
          OP_LOAD:    q_n = lwd;
          OP_CLEAR:   q_n = '0;
          OP_PRESET:  q_n = '1;
          OP_COMPARE: q_n = q;
          default:    q_n = q;
        endcase
        state_n = CHECK;
      end

      CHECK: begin
        match_n  = (q == pat_x) || (q == pat_y);
        done_n   = 1'b1;
        gnt_n    = '0;
        busy_n   = 1'b0;
        rr_ptr_n = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
        state_n  = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  // State and bank registers; clr wins over any edge action
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= IDLE;
      q      <= '0;
      gnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      match  <= 1'b0;
      rr_ptr <= '0;
      win    <= '0;
      lop    <= OP_LOAD;
      lwd    <= '0;
    end else begin
      state  <= state_n;
      q      <= q_n;
      gnt    <= gnt_n;
      busy   <= busy_n;
      done   <= done_n;
      match  <= match_n;
      rr_ptr <= rr_ptr_n;
      win    <= win_n;
      lop    <= lop_n;
      lwd    <= lwd_n;
    end
  end

  assign qb = ~q;

endmodule

// File: doc/ff_bank_sched.md
Name: ff_bank_sched

Overview:
- Scheduler that shares one WIDTH-bit register bank (async-clear D flip-flops) between NREQ requesters.
- Each granted requester performs one operation on the bank: load, clear, preset or compare.
- After each operation the block reports whether the bank value is in the set {pat_x, pat_y}.
- Sits between the requesting control agents and the flop bank; it is the only writer of the bank.

Parameters:
- NREQ, 4, number of requesters (≥2).
- WIDTH, 8, bank width in bits.

Ports:
- clk  in  1  clock, rising edge.
- clr  in  1  reset, asynchronous, active-high.
- req  in  NREQ  per-requester request, level; hold until grant is seen.
- op  in  2*NREQ  per-requester opcode, slice i = op[2i+1:2i]: 00 LOAD, 01 CLEAR, 10 PRESET, 11 COMPARE.
- wdata  in  WIDTH*NREQ  per-requester load data, slice i = wdata[WIDTH*i +: WIDTH].
- pat_x  in  WIDTH  membership pattern X.
- pat_y  in  WIDTH  membership pattern Y.
- gnt  out  NREQ  one-hot grant.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- match  out  1  membership result of the last completed operation.
- q  out  WIDTH  bank contents.
- qb  out  WIDTH  bank complement, always ~q (combinational).

Behaviour:
- Reset: clr=1 forces, immediately and without a clock edge:
  - state=IDLE, q=0 (so qb=all ones), gnt=0, busy=0, done=0, match=0, rr_ptr=0.
  - clr has priority over every clock-edge action.
- FSM states: IDLE, APPLY, CHECK.
- IDLE:
  - If req≠0 at an edge: select winner by round-robin, searching rr_ptr, rr_ptr+1, … mod NREQ.
  - Latch the winner's op and wdata; gnt<=onehot(winner); busy<=1; go to APPLY.
  - Otherwise stay in IDLE with gnt=0 and busy=0.
- APPLY: one cycle; at the exit edge update q from the latched op, then go to CHECK:
  - LOAD: q<=latched wdata.
  - CLEAR: q<=0.
  - PRESET: q<=all ones.
  - COMPARE: q unchanged.
- CHECK: one cycle; at the exit edge:
  - match<=(q==pat_x)||(q==pat_y), using the updated q and pat_x/pat_y as sampled at this edge.
  - done<=1; gnt<=0; busy<=0; rr_ptr<=(winner+1) mod NREQ; go to IDLE.
- done is high for exactly the first IDLE cycle after CHECK, then clears.
- Arbitration may also occur at the edge ending that done cycle, giving back-to-back operations: one operation per 3 cycles.
- Latency, counting from the edge where req is sampled in IDLE as edge 0:
  - gnt visible after edge 0.
  - q updated at edge 1.
  - done/match visible after edge 2.
- gnt stays stable through APPLY and CHECK. Changes to req, op or wdata after edge 0 have no effect on the current operation.
- A req dropped before it is granted is ignored; no state is retained for it.
- match holds its value until the next done; it is never cleared except by clr.
- Simultaneous requests: only the round-robin winner is served. Losers keep req high and are served in later rounds.
- Wrap-around: winner=NREQ-1 sets rr_ptr=0.
- clr asserted mid-operation (APPLY or CHECK): operation aborted, no done pulse, all outputs take their reset values.
- After clr deasserts, the first arbitration starts at requester 0.

Test Plan (WIDTH=8, NREQ=4):
- Reset: clr=1 at any time → q=00, qb=FF, gnt=0, done=0, match=0; deassert and idle 5 cycles → all unchanged.
- Single LOAD: req[1]=1, op1=00, wdata1=8'hA5, pat_x=A5, pat_y=00 → gnt=0010 after edge 0, q=A5 after edge 1, done=1 and match=1 after edge 2; done low the following cycle.
- PRESET then COMPARE: req2 PRESET with pat_x=3C, pat_y=FF → q=FF, match=1. Then req2 COMPARE with pat_y=00 → q stays FF, match=0.
- Round-robin: req=1111 held, all ops LOAD with distinct data → grant order 0,1,2,3,0; each done spaced exactly 3 cycles apart; q equals the data of the granted requester.
- Abort: req0 LOAD 8'h77 (q previously 5A); pulse clr during CHECK → q=00, no done pulse. Next request with req=0110 → requester 1 wins first.
- Late change: after gnt[3], change wdata3 from 11 to 22 → q=11, proving wdata was latched at grant.
